// File: rtl/fetch_frontend.sv
// Instruction fetch front end: PC sequencing, redirect handling and a DEPTH-entry
// fetch queue toward decode. Define FETCH_BYPASS_EN to let an empty queue forward imem data combinationally.
module fetch_frontend #(
   parameter int              WORD      = 64,
   parameter int              INSTR_LEN = 32,
   parameter int              DEPTH     = 4,
   parameter logic [WORD-1:0] RESET_PC  = '0
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         pc_src,
   input  logic [WORD-1:0]              branch_target,
   output logic                         imem_req,
   output logic [WORD-1:0]              imem_addr,
   input  logic [INSTR_LEN-1:0]         imem_instr,
   output logic                         dec_valid,
   input  logic                         dec_ready,
   output logic [INSTR_LEN-1:0]         dec_instr,
   output logic [WORD-1:0]              dec_pc,
   output logic [WORD-1:0]              dec_incremented_pc,
   output logic [$clog2(DEPTH):0]       q_count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0]   FULL_CNT   = CW'(DEPTH);
   localparam logic [WORD-1:0] ALIGN_MASK = ~(WORD'(3));

   logic [WORD-1:0]      pc_q, pc_d;
   logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
   logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
   logic [CW-1:0]        count_q, count_d;
   logic [WORD-1:0]      pc_mem_q    [DEPTH];
   logic [INSTR_LEN-1:0] instr_mem_q [DEPTH];

   logic q_nonempty;
   logic q_full;
   logic q_pop;
   logic q_push;
   logic bypass_take;

   assign q_nonempty = (count_q != '0);
   assign q_full     = (count_q == FULL_CNT);
   assign q_pop      = q_nonempty && dec_ready;

   // A full queue can still accept a fetch when the head leaves in the same edge.
   assign imem_req  = !reset && !pc_src && (!q_full || q_pop);
   assign imem_addr = pc_q;

`ifdef FETCH_BYPASS_EN
   logic bypass_hit;
   assign bypass_hit  = !q_nonempty && imem_req;
   assign bypass_take = bypass_hit && dec_ready;
   assign dec_valid   = q_nonempty || bypass_hit;
   assign dec_instr   = bypass_hit ? imem_instr : instr_mem_q[rd_ptr_q];
   assign dec_pc      = bypass_hit ? pc_q       : pc_mem_q[rd_ptr_q];
`else
   assign bypass_take = 1'b0;
   assign dec_valid   = q_nonempty;
   assign dec_instr   = instr_mem_q[rd_ptr_q];
   assign dec_pc      = pc_mem_q[rd_ptr_q];
`endif

   assign dec_incremented_pc = dec_pc + WORD'(4);
   assign q_count            = count_q;
   assign q_push             = imem_req && !bypass_take;

   always_comb begin
      pc_d     = pc_q;
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      if (reset) begin
         pc_d     = RESET_PC;
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end else if (pc_src) begin
         // A head popped in this edge still counts as delivered; the rest is flushed.
         pc_d     = branch_target & ALIGN_MASK;
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (q_push) wr_ptr_d = wr_ptr_q + AW'(1);
         if (q_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
         count_d = count_q + CW'(q_push) - CW'(q_pop);
         if (imem_req) pc_d = pc_q + WORD'(4);
      end
   end

   always_ff @(posedge clk) begin
      pc_q     <= pc_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
   end

   // Entry storage needs no reset: occupancy alone decides what is valid.
   always_ff @(posedge clk) begin
      if (q_push) begin
         pc_mem_q[wr_ptr_q]    <= pc_q;
         instr_mem_q[wr_ptr_q] <= imem_instr;
      end
   end

endmodule
